// File: rtl/packet_builder_pkg.sv
// Shared framing constants and FSM state encoding for the command packet link.
package packet_builder_pkg;

  localparam int          COMMAND_WIDTH = 16;
  localparam int          LENGTH_WIDTH  = 24;
  localparam logic [15:0] HEADER        = 16'hBACD;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SEND_HEADER  = 3'd1,
    ST_SEND_COMMAND = 3'd2,
    ST_SEND_PAYLOAD = 3'd3,
    ST_DONE         = 3'd4
  } state_e;

endpackage

// File: rtl/packet_builder_bit_serializer.sv
// MSB-first parallel-load shift register with a bit-index down-counter.
// last_o flags that the bit currently at the MSB is the final one of the word.
module packet_builder_bit_serializer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_en_i,
  output logic         msb_o,
  output logic         last_o
);

  localparam int IW = $clog2(W);

  logic [W-1:0]  shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;

  // Load wins over shift so the next word can be queued on the last-bit cycle.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load_i) begin
      shift_d = data_i;
      idx_d   = IW'(W - 1);
    end else if (shift_en_i) begin
      shift_d = {shift_q[W-2:0], 1'b0};
      if (idx_q != '0) idx_d = idx_q - IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign msb_o  = shift_q[W-1];
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/packet_builder.sv
// Serialises header, command and forwarded payload bits onto a tx_ready-paced bit link.
//   state           | meaning
//   ST_IDLE         | waiting for start; latches command and payload length
//   ST_SEND_HEADER  | shifting out the sync word
//   ST_SEND_COMMAND | shifting out the latched command
//   ST_SEND_PAYLOAD | forwarding upstream bits until the length counter empties
//   ST_DONE         | one cycle before returning to idle; done pulses next cycle
module packet_builder
  import packet_builder_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [COMMAND_WIDTH-1:0] command_i,
  input  logic [LENGTH_WIDTH-1:0]  payload_length_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic                     input_bit_i,
  input  logic                     is_new_input_bit_i,
  output logic                     input_ready_o,
  input  logic                     tx_ready_i,
  output logic                     output_bit_o,
  output logic                     is_new_output_bit_o
);

  state_e                   state_q, state_d;
  logic [COMMAND_WIDTH-1:0] cmd_q, cmd_d;
  logic [LENGTH_WIDTH-1:0]  rem_q, rem_d;
  logic                     out_bit_q, out_bit_d;
  logic                     strobe_q, strobe_d;
  logic                     done_q, done_d;

  logic                     ser_load, ser_shift, ser_msb, ser_last;
  logic [COMMAND_WIDTH-1:0] ser_data;

  packet_builder_bit_serializer #(.W(COMMAND_WIDTH)) u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ser_load),
    .data_i     (ser_data),
    .shift_en_i (ser_shift),
    .msb_o      (ser_msb),
    .last_o     (ser_last)
  );

  assign input_ready_o = (state_q == ST_SEND_PAYLOAD) && tx_ready_i && (rem_q != '0);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rem_d     = rem_q;
    out_bit_d = out_bit_q;
    strobe_d  = 1'b0;
    done_d    = (state_q == ST_DONE);
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_data  = HEADER;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cmd_d    = command_i;
          rem_d    = payload_length_i;
          ser_load = 1'b1;
          state_d  = ST_SEND_HEADER;
        end
      end
      ST_SEND_HEADER, ST_SEND_COMMAND: begin
        if (tx_ready_i) begin
          ser_shift = 1'b1;
          out_bit_d = ser_msb;
          strobe_d  = 1'b1;
          if (ser_last) begin
            if (state_q == ST_SEND_HEADER) begin
              ser_load = 1'b1;
              ser_data = cmd_q;
              state_d  = ST_SEND_COMMAND;
            end else begin
              state_d = (rem_q != '0) ? ST_SEND_PAYLOAD : ST_DONE;
            end
          end
        end
      end
      ST_SEND_PAYLOAD: begin
        if (is_new_input_bit_i && input_ready_o) begin
          out_bit_d = input_bit_i;
          strobe_d  = 1'b1;
          rem_d     = rem_q - LENGTH_WIDTH'(1);
          if (rem_q == LENGTH_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      rem_q     <= '0;
      out_bit_q <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rem_q     <= rem_d;
      out_bit_q <= out_bit_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  assign busy_o              = (state_q != ST_IDLE);
  assign done_o              = done_q;
  assign output_bit_o        = out_bit_q;
  assign is_new_output_bit_o = strobe_q;

endmodule
